cv32e40x_fetch_bus_arbiter: RTL and testbench

// - Shares the single OBI instruction port between two fetch requesters.
//   - Requester 0: prefetch buffer.
//   - Requester 1: secondary fetcher, e.g. table-jump or trace replay.
// - Sits between the IF stage and instruction memory.
// - Holds OBI address-phase stability and limits outstanding transactions.
// - Routes in-order responses back using a granted-ID FIFO.

---
 rtl/cv32e40x_pkg.sv | 14 +
 rtl/cv32e40x_fetch_arb_id_fifo.sv | 54 +++++
 rtl/cv32e40x_fetch_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_cv32e40x_fetch_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40x_pkg.sv
// Shared types for the fetch bus arbiter: arbiter FSM states and requester IDs.
// Related build option: CV32E40X_FETCH_ARB_PRIO_EN (selects the arbitration policy in the top).
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_HOLD0 = 2'd1,
        ARB_HOLD1 = 2'd2
    } arb_state_e;

    localparam logic ARB_ID_M0 = 1'b0;
    localparam logic ARB_ID_M1 = 1'b1;

endpackage

// File: rtl/cv32e40x_fetch_arb_id_fifo.sv
// In-order record of which requester owns each granted OBI transaction.
// A push into a full FIFO is accepted when a pop frees a slot in the same cycle.
module cv32e40x_fetch_arb_id_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head,
    output logic empty,
    output logic full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_id;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/cv32e40x_fetch_bus_arbiter.sv
// Shares one OBI instruction port between the prefetch buffer (m0) and a secondary fetcher (m1).
// Define CV32E40X_FETCH_ARB_PRIO_EN for strict m0 priority; default is round-robin.
module cv32e40x_fetch_bus_arbiter
    import cv32e40x_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic [2:0]  outstanding_o
);

    arb_state_e state_q, state_d;
    logic       last_grant_q;
    logic [2:0] cnt_q;
    logic       rst_q;
    logic       blocked;
    logic       winner;
    logic       sel;
    logic       issue;
    logic       can_issue;
    logic       gnt_fire;
    logic       pop;
    logic       resp_valid;
    logic       fifo_head;
    logic       fifo_empty;
    logic       fifo_full;

    // Outputs are forced quiet during reset and for one cycle after it.
    assign blocked = rst | rst_q;

    always_comb begin
        winner = ARB_ID_M0;
`ifdef CV32E40X_FETCH_ARB_PRIO_EN
        winner = m0_req_i ? ARB_ID_M0 : ARB_ID_M1;
`else
        if (m0_req_i && m1_req_i) begin
            winner = ~last_grant_q;
        end else begin
            winner = m0_req_i ? ARB_ID_M0 : ARB_ID_M1;
        end
`endif
    end

    // A returning response frees a slot in the same cycle, so it also unblocks issue.
    assign can_issue = (m0_req_i | m1_req_i) &
                       ((cnt_q < 3'(MAX_OUTSTANDING)) | instr_rvalid_i);

    always_comb begin
        state_d = state_q;
        sel     = winner;
        issue   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                sel   = winner;
                issue = can_issue & ~blocked;
                if (issue && !instr_gnt_i) begin
                    state_d = (winner == ARB_ID_M1) ? ARB_HOLD1 : ARB_HOLD0;
                end
            end
            ARB_HOLD0: begin
                sel   = ARB_ID_M0;
                issue = ~blocked;
                if (issue && instr_gnt_i) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_HOLD1: begin
                sel   = ARB_ID_M1;
                issue = ~blocked;
                if (issue && instr_gnt_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign instr_req_o  = issue;
    assign instr_addr_o = issue ? ((sel == ARB_ID_M1) ? m1_addr_i : m0_addr_i) : 32'h0;
    assign gnt_fire     = issue & instr_gnt_i;
    assign m0_gnt_o     = gnt_fire & (sel == ARB_ID_M0);
    assign m1_gnt_o     = gnt_fire & (sel == ARB_ID_M1);

    // Responses with no recorded owner are stale and silently dropped.
    assign pop         = instr_rvalid_i & ~fifo_empty & ~rst;
    assign resp_valid  = pop & ~blocked;
    assign m0_rvalid_o = resp_valid & (fifo_head == ARB_ID_M0);
    assign m1_rvalid_o = resp_valid & (fifo_head == ARB_ID_M1);
    assign rdata_o     = blocked ? 32'h0 : instr_rdata_i;
    assign err_o       = ~blocked & instr_err_i;
    assign outstanding_o = blocked ? 3'd0 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= ARB_ID_M1;
            cnt_q        <= 3'd0;
            rst_q        <= 1'b1;
        end else begin
            state_q <= state_d;
            rst_q   <= 1'b0;
            if (gnt_fire) begin
                last_grant_q <= sel;
            end
            cnt_q <= cnt_q + 3'(gnt_fire) - 3'(pop);
        end
    end

    cv32e40x_fetch_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (gnt_fire),
        .push_id (sel),
        .pop     (pop),
        .head    (fifo_head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        pop |-> !fifo_empty);

    a_hold0_stable: assert property (@(posedge clk) disable iff (rst)
        (state_q == ARB_HOLD0) |-> (m0_req_i && $stable(m0_addr_i)));

    a_hold1_stable: assert property (@(posedge clk) disable iff (rst)
        (state_q == ARB_HOLD1) |-> (m1_req_i && $stable(m1_addr_i)));

    a_cnt_max: assert property (@(posedge clk) disable iff (rst)
        (cnt_q <= 3'(MAX_OUTSTANDING)) && !(fifo_full && cnt_q != 3'(MAX_OUTSTANDING)));

endmodule

// File: tb/tb_cv32e40x_fetch_bus_arbiter.sv
// Directed bench for the fetch bus arbiter; a queue of expected response owners is
// filled on each grant and drained as responses come back.
module tb_cv32e40x_fetch_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m0_gnt_o;
    logic        m0_rvalid_o;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic        m1_gnt_o;
    logic        m1_rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;
    logic [2:0]  outstanding_o;

    int   checkCount = 0;
    int   passCount  = 0;
    logic sbQueue[$];

    cv32e40x_fetch_bus_arbiter #(
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .m0_req_i       (m0_req),
        .m0_addr_i      (m0_addr),
        .m0_gnt_o       (m0_gnt_o),
        .m0_rvalid_o    (m0_rvalid_o),
        .m1_req_i       (m1_req),
        .m1_addr_i      (m1_addr),
        .m1_gnt_o       (m1_gnt_o),
        .m1_rvalid_o    (m1_rvalid_o),
        .rdata_o        (rdata_o),
        .err_o          (err_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt),
        .instr_rvalid_i (instr_rvalid),
        .instr_rdata_i  (instr_rdata),
        .instr_err_i    (instr_err),
        .outstanding_o  (outstanding_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic r0, input logic [31:0] a0,
                                 input logic r1, input logic [31:0] a1,
                                 input logic gnt, input logic rv,
                                 input logic [31:0] rd, input logic er);
        m0_req       = r0;
        m0_addr      = a0;
        m1_req       = r1;
        m1_addr      = a1;
        instr_gnt    = gnt;
        instr_rvalid = rv;
        instr_rdata  = rd;
        instr_err    = er;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed=%0h required=%0h", tag, obs, exp);
    endtask

    task automatic checkResponse(input string tag, input logic [31:0] expData, input logic expErr);
        logic expId;
        if (sbQueue.size() == 0) begin
            checkCount++;
            $error("[TB] FAIL %s_sb: observed=response required=no_pending_owner", tag);
        end else begin
            expId = sbQueue.pop_front();
            checkOutput({tag, "_m0_rvalid"}, 32'(m0_rvalid_o), 32'(expId == 1'b0));
            checkOutput({tag, "_m1_rvalid"}, 32'(m1_rvalid_o), 32'(expId == 1'b1));
            checkOutput({tag, "_rdata"}, rdata_o, expData);
            checkOutput({tag, "_err"}, 32'(err_o), 32'(expErr));
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic expId;

        // Reset and the following cycle must keep every output at zero.
        rst = 1'b1;
        applyStimulus(1'b1, 32'h1000, 1'b1, 32'h2000, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        nextCycle();
        @(negedge clk);
        checkOutput("rst_req", 32'(instr_req_o), 32'd0);
        checkOutput("rst_addr", instr_addr_o, 32'd0);
        checkOutput("rst_m0_gnt", 32'(m0_gnt_o), 32'd0);
        checkOutput("rst_m0_rvalid", 32'(m0_rvalid_o), 32'd0);
        checkOutput("rst_rdata", rdata_o, 32'd0);
        checkOutput("rst_err", 32'(err_o), 32'd0);
        checkOutput("rst_outstanding", 32'(outstanding_o), 32'd0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postrst_req", 32'(instr_req_o), 32'd0);
        checkOutput("postrst_m1_gnt", 32'(m1_gnt_o), 32'd0);
        checkOutput("postrst_rdata", rdata_o, 32'd0);
        checkOutput("postrst_m1_rvalid", 32'(m1_rvalid_o), 32'd0);
        nextCycle();

        // Round-robin tie: grants alternate starting with m0, responses follow one cycle later.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(k < 4, 32'h1000 + 32'(k * 8), k < 4, 32'h2000 + 32'(k * 8),
                          k < 4, k > 0, 32'hA000_0000 + 32'(k), k == 2);
            @(negedge clk);
            checkOutput("rr_outstanding", 32'(outstanding_o), (k == 0) ? 32'd0 : 32'd1);
            if (k > 0) checkResponse("rr_rsp", 32'hA000_0000 + 32'(k), k == 2);
            if (k < 4) begin
                expId = logic'(k % 2);
                checkOutput("rr_req", 32'(instr_req_o), 32'd1);
                checkOutput("rr_addr", instr_addr_o,
                            expId ? 32'h2000 + 32'(k * 8) : 32'h1000 + 32'(k * 8));
                checkOutput("rr_m0_gnt", 32'(m0_gnt_o), 32'(!expId));
                checkOutput("rr_m1_gnt", 32'(m1_gnt_o), 32'(expId));
                sbQueue.push_back(expId);
            end else begin
                checkOutput("rr_idle_req", 32'(instr_req_o), 32'd0);
            end
            nextCycle();
        end

        // Hold: m1 stalls three cycles without grant; m0 arrives meanwhile and must wait.
        for (int h = 0; h < 4; h++) begin
            applyStimulus(h > 0, 32'h200, 1'b1, 32'h100, h == 3, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            checkOutput("hold_req", 32'(instr_req_o), 32'd1);
            checkOutput("hold_addr", instr_addr_o, 32'h100);
            checkOutput("hold_m0_gnt", 32'(m0_gnt_o), 32'd0);
            checkOutput("hold_m1_gnt", 32'(m1_gnt_o), 32'(h == 3));
            if (h == 3) sbQueue.push_back(1'b1);
            nextCycle();
        end
        applyStimulus(1'b1, 32'h200, 1'b1, 32'h104, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("hold_next_addr", instr_addr_o, 32'h200);
        checkOutput("hold_next_m0_gnt", 32'(m0_gnt_o), 32'd1);
        checkOutput("hold_next_m1_gnt", 32'(m1_gnt_o), 32'd0);
        sbQueue.push_back(1'b0);
        nextCycle();

        // Full: two outstanding, so no issue until a response frees a slot.
        for (int f = 0; f < 2; f++) begin
            applyStimulus(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            checkOutput("full_req", 32'(instr_req_o), 32'd0);
            checkOutput("full_m0_gnt", 32'(m0_gnt_o), 32'd0);
            checkOutput("full_outstanding", 32'(outstanding_o), 32'd2);
            nextCycle();
        end
        applyStimulus(1'b1, 32'h304, 1'b0, 32'h0, 1'b1, 1'b1, 32'hB000_0002, 1'b0);
        @(negedge clk);
        checkOutput("resume_req", 32'(instr_req_o), 32'd1);
        checkOutput("resume_addr", instr_addr_o, 32'h304);
        checkOutput("resume_m0_gnt", 32'(m0_gnt_o), 32'd1);
        checkResponse("resume_rsp", 32'hB000_0002, 1'b0);
        sbQueue.push_back(1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB000_0003, 1'b1);
        @(negedge clk);
        checkOutput("simul_outstanding", 32'(outstanding_o), 32'd2);
        checkResponse("drain_rsp0", 32'hB000_0003, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB000_0004, 1'b0);
        @(negedge clk);
        checkOutput("drain_outstanding", 32'(outstanding_o), 32'd1);
        checkResponse("drain_rsp1", 32'hB000_0004, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("empty_outstanding", 32'(outstanding_o), 32'd0);
        checkOutput("empty_m0_rvalid", 32'(m0_rvalid_o), 32'd0);
        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
        nextCycle();

        // Reset with two transactions in flight; their late responses must vanish.
        applyStimulus(1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("mid_m0_gnt", 32'(m0_gnt_o), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h500, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("mid_m1_gnt", 32'(m1_gnt_o), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("mid_outstanding", 32'(outstanding_o), 32'd2);
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_outstanding", 32'(outstanding_o), 32'd0);
        nextCycle();
        rst = 1'b0;
        nextCycle();
        for (int s = 0; s < 2; s++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0000 + 32'(s), 1'b0);
            @(negedge clk);
            checkOutput("stale_m0_rvalid", 32'(m0_rvalid_o), 32'd0);
            checkOutput("stale_m1_rvalid", 32'(m1_rvalid_o), 32'd0);
            checkOutput("stale_rdata", rdata_o, 32'hC000_0000 + 32'(s));
            checkOutput("stale_outstanding", 32'(outstanding_o), 32'd0);
            nextCycle();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("after_stale_outstanding", 32'(outstanding_o), 32'd0);
        nextCycle();

        // Continuous contention, then m0 drops out and m1 must be served.
        for (int p = 0; p < 5; p++) begin
            applyStimulus(p < 3, 32'h600 + 32'(p * 4), p < 4, 32'h700 + 32'(p * 4),
                          p < 4, p > 0, 32'hD000_0000 + 32'(p), 1'b0);
            @(negedge clk);
            if (p > 0) checkResponse("pri_rsp", 32'hD000_0000 + 32'(p), 1'b0);
            if (p < 4) begin
`ifdef CV32E40X_FETCH_ARB_PRIO_EN
                expId = (p == 3);
`else
                expId = (p == 3) ? 1'b1 : logic'(p % 2);
`endif
                checkOutput("pri_addr", instr_addr_o,
                            expId ? 32'h700 + 32'(p * 4) : 32'h600 + 32'(p * 4));
                checkOutput("pri_m0_gnt", 32'(m0_gnt_o), 32'(!expId));
                checkOutput("pri_m1_gnt", 32'(m1_gnt_o), 32'(expId));
                sbQueue.push_back(expId);
            end
            nextCycle();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("final_outstanding", 32'(outstanding_o), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
